// File: rtl/spi_cmd_regs.sv
// -----------------------------------------------------------------------------
// spi_cmd_regs
//
// Command decoder and register bank that sits behind a 32-bit SPI slave.
// Each completed frame (falling edge of busy) is captured, decoded as a
// register read or write, and answered with a response word. The slave
// shifts that word out on MISO during the following frame.
//
// Frame  : [31]=WR, [30:24]=ADDR, [23:16] ignored, [15:0]=WDATA
// Map    : 0 = ID (read-only), 1 = STATUS, 2..NUM_REGS-1 = R/W,
//          >= NUM_REGS = invalid (sets sticky bad_addr)
// STATUS : {frame_cnt[7:0], 6'b0, overrun, bad_addr}; writes are W1C on [1:0]
// Resp   : {1'b1, ADDR, frame_cnt_new, rdata}
//
// Ports
//   clk               system clock, shared with the SPI slave
//   rst               synchronous reset, active-high
//   busy              SPI slave busy; 1->0 marks a completed frame
//   data_had_receive  received frame, stable while busy=0
//   data_to_out       response word for the next frame
//   reg_out           flat R/W registers, slot k = reg_out[16k+15:16k]
//   wr_strobe         one-cycle pulse on a write to a R/W register
//   wr_addr           address of that write
//   wr_data           data of that write
//
// Processing runs IDLE -> EXEC -> LOAD, one clock each, so data_to_out is
// updated three clocks after busy falls.
// -----------------------------------------------------------------------------
module spi_cmd_regs #(
    parameter int          NUM_REGS = 16,
    parameter logic [15:0] ID_VALUE = 16'h5A01
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   busy,
    input  logic [31:0]            data_had_receive,
    output logic [31:0]            data_to_out,
    output logic [NUM_REGS*16-1:0] reg_out,
    output logic                   wr_strobe,
    output logic [6:0]             wr_addr,
    output logic [15:0]            wr_data
);

    localparam int         AW          = $clog2(NUM_REGS);
    localparam logic [7:0] NUM_REGS_U8 = 8'(NUM_REGS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t        state_reg, state_next;

    logic          busy_d_reg;
    logic          cmd_wr_reg;
    logic [6:0]    cmd_addr_reg;
    logic [15:0]   cmd_wdata_reg;
    logic [7:0]    frame_cnt_reg;
    logic          bad_addr_reg, bad_addr_next;
    logic          overrun_reg, overrun_next;
    logic [31:0]   resp_reg;
    logic [31:0]   data_to_out_reg;
    logic          wr_strobe_reg;
    logic [6:0]    wr_addr_reg;
    logic [15:0]   wr_data_reg;
    logic [15:0]   regs_reg [NUM_REGS];

    // Bits [23:16] of the frame carry no meaning for this block.
    logic          unused_frame_bits;
    assign unused_frame_bits = ^data_had_receive[23:16];

    logic          frame_done;
    logic          addr_valid;
    logic [AW-1:0] cmd_idx;
    logic [7:0]    frame_cnt_new;
    logic [1:0]    status_clr;
    logic          set_bad;
    logic          do_reg_wr;
    logic [15:0]   rdata;
    logic          exec_active;

    // busy_d resets to 0 so a busy that is already low after reset does not
    // look like a completed frame.
    assign frame_done    = busy_d_reg & ~busy;
    assign exec_active   = (state_reg == S_EXEC);
    assign addr_valid    = ({1'b0, cmd_addr_reg} < NUM_REGS_U8);
    assign cmd_idx       = cmd_addr_reg[AW-1:0];
    assign frame_cnt_new = frame_cnt_reg + 8'd1;

    // ---------------------------------------------------------------------
    // FSM next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (frame_done) state_next = S_EXEC;
            S_EXEC:  state_next = S_LOAD;
            S_LOAD:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Command decode; results are only committed while in EXEC.
    // ---------------------------------------------------------------------
    always_comb begin
        rdata      = 16'h0000;
        status_clr = 2'b00;
        set_bad    = 1'b0;
        do_reg_wr  = 1'b0;
        if (!addr_valid) begin
            set_bad = 1'b1;
        end else if (cmd_addr_reg == 7'd0) begin
            rdata = ID_VALUE;
        end else if (cmd_addr_reg == 7'd1) begin
            if (cmd_wr_reg) status_clr = cmd_wdata_reg[1:0];
            // Read-back reflects the flags after this frame's clear.
            rdata = {frame_cnt_new, 6'b0,
                     overrun_reg & ~status_clr[1],
                     bad_addr_reg & ~status_clr[0]};
        end else if (cmd_wr_reg) begin
            do_reg_wr = 1'b1;
            rdata     = cmd_wdata_reg;
        end else begin
            rdata = regs_reg[cmd_idx];
        end
    end

    // ---------------------------------------------------------------------
    // Sticky flags. A concurrent set wins over a W1C clear.
    // ---------------------------------------------------------------------
    always_comb begin
        bad_addr_next = bad_addr_reg;
        overrun_next  = overrun_reg;
        if (exec_active) begin
            bad_addr_next = (bad_addr_reg & ~status_clr[0]) | set_bad;
            overrun_next  = overrun_reg & ~status_clr[1];
        end
        // A frame arriving while busy processing is dropped; a response that
        // cannot be loaded because the next frame already started is lost.
        if ((frame_done && state_reg != S_IDLE) ||
            (state_reg == S_LOAD && busy)) begin
            overrun_next = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            busy_d_reg      <= 1'b0;
            cmd_wr_reg      <= 1'b0;
            cmd_addr_reg    <= 7'd0;
            cmd_wdata_reg   <= 16'h0000;
            frame_cnt_reg   <= 8'd0;
            bad_addr_reg    <= 1'b0;
            overrun_reg     <= 1'b0;
            resp_reg        <= 32'h0;
            data_to_out_reg <= 32'h0;
            wr_strobe_reg   <= 1'b0;
            wr_addr_reg     <= 7'd0;
            wr_data_reg     <= 16'h0000;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= 16'h0000;
            end
        end else begin
            state_reg     <= state_next;
            busy_d_reg    <= busy;
            bad_addr_reg  <= bad_addr_next;
            overrun_reg   <= overrun_next;
            wr_strobe_reg <= exec_active & do_reg_wr;

            if (state_reg == S_IDLE && frame_done) begin
                cmd_wr_reg    <= data_had_receive[31];
                cmd_addr_reg  <= data_had_receive[30:24];
                cmd_wdata_reg <= data_had_receive[15:0];
            end

            if (exec_active) begin
                frame_cnt_reg <= frame_cnt_new;
                resp_reg      <= {1'b1, cmd_addr_reg, frame_cnt_new, rdata};
                if (do_reg_wr) begin
                    regs_reg[cmd_idx] <= cmd_wdata_reg;
                    wr_addr_reg       <= cmd_addr_reg;
                    wr_data_reg       <= cmd_wdata_reg;
                end
            end

            // Only touch the shift-out word while the slave is idle.
            if (state_reg == S_LOAD && !busy) begin
                data_to_out_reg <= resp_reg;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign data_to_out = data_to_out_reg;
    assign wr_strobe   = wr_strobe_reg;
    assign wr_addr     = wr_addr_reg;
    assign wr_data     = wr_data_reg;

    // ID and STATUS live elsewhere, so their slots in reg_out read as zero.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
            if (gi < 2) begin : g_fixed
                assign reg_out[gi*16 +: 16] = 16'h0000;
            end else begin : g_rw
                assign reg_out[gi*16 +: 16] = regs_reg[gi];
            end
        end
    endgenerate

endmodule
